// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: state encodings, default widths
// and the latched sign-flag bundle.
package div_seq_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_ZERO = 2'b01;
    localparam logic [1:0] DIV_BUSY = 2'b10;
    localparam logic [1:0] DIV_DONE = 2'b11;

    typedef struct packed {
        logic negQ;
        logic negR;
    } signFlags_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Control/data bus between the divide sequencer (master) and the restoring divider core (slave).
interface div_seq_ctrl_if
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] core_op_a;
    logic [WIDTH-1:0] core_op_b;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;

    modport master (
        output core_load, core_step, core_op_a, core_op_b,
        input  core_q, core_r
    );

    modport slave (
        input  core_load, core_step, core_op_a, core_op_b,
        output core_q, core_r
    );
endinterface

// File: rtl/div_seq_ctrl_sign_fix.sv
// Operand magnitude extraction on the way into the core and quotient/remainder
// negation on the way out. Purely combinational.
module div_seq_ctrl_sign_fix
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             signedOp,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] magA,
    output logic [WIDTH-1:0] magB,
    output signFlags_t       startFlags,
    input  signFlags_t       heldFlags,
    input  logic [WIDTH-1:0] coreQ,
    input  logic [WIDTH-1:0] coreR,
    output logic [WIDTH-1:0] qOut,
    output logic [WIDTH-1:0] rOut
);
    logic negA;
    logic negB;

    assign negA = signedOp & dividend[WIDTH-1];
    assign negB = signedOp & divisor[WIDTH-1];

    // The most negative value negates to itself, which is still its correct unsigned magnitude.
    assign magA = negA ? -dividend : dividend;
    assign magB = negB ? -divisor  : divisor;

    assign startFlags.negQ = negA ^ negB;
    assign startFlags.negR = negA;

    assign qOut = heldFlags.negQ ? -coreQ : coreQ;
    assign rOut = heldFlags.negR ? -coreR : coreR;

endmodule

// File: rtl/div_seq_ctrl.sv
// EX-stage sequencer for the iterative radix-2 divider: stalls the pipeline while the
// core iterates, then writes the sign-corrected {HI,LO} pair with a one-cycle strobe.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_validE,
    input  logic                 signed_divE,
    input  logic                 flushE,
    input  logic [WIDTH-1:0]     srcaE,
    input  logic [WIDTH-1:0]     srcbE,
    div_seq_ctrl_if.master       core,
    output logic                 stall_divE,
    output logic [2*WIDTH-1:0]   div_resultE,
    output logic                 div_result_validE
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         stateReg;
    logic [1:0]         stateNext;
    logic [CNT_W-1:0]   cntReg;
    logic               loadReg;
    logic [WIDTH-1:0]   opAReg;
    logic [WIDTH-1:0]   opBReg;
    signFlags_t         signReg;
    logic               zeroReg;
    logic [2*WIDTH-1:0] resultReg;
    logic               validReg;

    logic               start;
    logic               divByZero;
    logic               writeBack;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    signFlags_t         startFlags;
    logic [WIDTH-1:0]   qOut;
    logic [WIDTH-1:0]   rOut;

    assign start     = (stateReg == DIV_IDLE) && div_validE && !flushE;
    assign divByZero = (srcbE == '0);
    assign writeBack = (stateReg == DIV_DONE) && !flushE;

    div_seq_ctrl_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .signedOp   (signed_divE),
        .dividend   (srcaE),
        .divisor    (srcbE),
        .magA       (magA),
        .magB       (magB),
        .startFlags (startFlags),
        .heldFlags  (signReg),
        .coreQ      (core.core_q),
        .coreR      (core.core_r),
        .qOut       (qOut),
        .rOut       (rOut)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            DIV_IDLE: if (start) stateNext = divByZero ? DIV_ZERO : DIV_BUSY;
            DIV_ZERO: stateNext = flushE ? DIV_IDLE : DIV_DONE;
            DIV_BUSY: begin
                if (flushE)
                    stateNext = DIV_IDLE;
                else if (cntReg == LAST_CNT)
                    stateNext = DIV_DONE;
            end
            default:  stateNext = DIV_IDLE;
        endcase
    end

    // DONE never stalls: the divide retires this cycle and must not be re-launched by itself.
    always_comb begin
        stall_divE = 1'b0;
        case (stateReg)
            DIV_IDLE: stall_divE = div_validE & ~flushE;
            DIV_ZERO: stall_divE = ~flushE;
            DIV_BUSY: stall_divE = ~flushE;
            default:  stall_divE = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= DIV_IDLE;
            cntReg    <= '0;
            loadReg   <= 1'b0;
            opAReg    <= '0;
            opBReg    <= '0;
            signReg   <= '0;
            zeroReg   <= 1'b0;
            resultReg <= '0;
            validReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            loadReg  <= start && !divByZero;
            validReg <= writeBack;

            if (start && !divByZero) begin
                opAReg  <= magA;
                opBReg  <= magB;
                signReg <= startFlags;
                cntReg  <= '0;
            end else if (stateReg == DIV_BUSY) begin
                cntReg  <= cntReg + 1'b1;
            end

            if (start)
                zeroReg <= divByZero;

            // The dividend is still held in EX during DONE, so the zero-divisor result reads it directly.
            if (writeBack)
                resultReg <= zeroReg ? {srcaE, {WIDTH{1'b1}}} : {rOut, qOut};
        end
    end

    // The core loads and performs its first iteration in the same (first BUSY) cycle.
    assign core.core_load = loadReg;
    assign core.core_step = (stateReg == DIV_BUSY);
    assign core.core_op_a = opAReg;
    assign core.core_op_b = opBReg;

    assign div_resultE       = resultReg;
    assign div_result_validE = validReg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl with a behavioural restoring-divider core and an
// arithmetic reference model for DIV/DIVU results.
module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        div_validE;
    logic        signed_divE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stall_divE;
    logic [63:0] div_resultE;
    logic        div_result_validE;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          strobes = 0;
    int          expStrobes = 0;
    int          lastStrobe = 0;
    int          prevStrobe = 0;
    logic [63:0] sb[$];
    logic [63:0] lastRes = '0;

    logic [31:0] quoR = '0;
    logic [31:0] remR = '0;
    logic [31:0] divR = '0;

    div_seq_ctrl_if #(.WIDTH(32)) coreBus ();

    div_seq_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .div_validE        (div_validE),
        .signed_divE       (signed_divE),
        .flushE            (flushE),
        .srcaE             (srcaE),
        .srcbE             (srcbE),
        .core              (coreBus),
        .stall_divE        (stall_divE),
        .div_resultE       (div_resultE),
        .div_result_validE (div_result_validE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Behavioural restoring divider: load initialises, each step does one shift/subtract.
    always @(posedge clk) begin
        logic [32:0] r;
        logic [31:0] q;
        logic [31:0] d;
        r = {1'b0, remR};
        q = quoR;
        d = divR;
        if (coreBus.core_load) begin
            r = '0;
            q = coreBus.core_op_a;
            d = coreBus.core_op_b;
        end
        if (coreBus.core_step) begin
            r = {r[31:0], q[31]};
            q = {q[30:0], 1'b0};
            if (r >= {1'b0, d}) begin
                r = r - {1'b0, d};
                q[0] = 1'b1;
            end
        end
        remR <= r[31:0];
        quoR <= q;
        divR <= d;
    end
    assign coreBus.core_q = quoR;
    assign coreBus.core_r = remR;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint na;
        longint nb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            na = $signed(a);
            nb = $signed(b);
        end else begin
            na = {32'd0, a};
            nb = {32'd0, b};
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (div_result_validE) begin
            strobes++;
            prevStrobe = lastStrobe;
            lastStrobe = cycle;
            if (sb.size() == 0)
                chk("unexpected_strobe", div_result_validE, 1'b0);
            else
                chk("div_result", div_resultE, sb.pop_front());
        end
    end

    task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int flushAt, input int rstAt);
        int stalls;
        int loads;
        int steps;
        logic aborted;
        logic [63:0] exp;
        aborted = (flushAt >= 0) || (rstAt >= 0);
        @(posedge clk); #1;
        rst = 1'b0; flushE = 1'b0; div_validE = 1'b1;
        signed_divE = sgn; srcaE = a; srcbE = b;
        exp = refDiv(a, b, sgn);
        if (!aborted) begin
            sb.push_back(exp);
            lastRes = exp;
            expStrobes++;
        end
        stalls = 0; loads = 0; steps = 0;
        for (int cyc = 0; cyc <= 60; cyc++) begin
            if (cyc == flushAt) flushE = 1'b1;
            if (cyc == rstAt) begin
                rst = 1'b1;
                div_validE = 1'b0;
            end
            @(negedge clk);
            stalls += int'(stall_divE);
            loads  += int'(coreBus.core_load);
            steps  += int'(coreBus.core_step);
            if (cyc == flushAt) begin
                chk("stall_in_flush_cycle", stall_divE, 1'b0);
                break;
            end
            if (cyc == rstAt) break;
            if (!stall_divE) break;
            @(posedge clk); #1;
        end
        if (!aborted) begin
            chk("stall_cycles", stalls, (b == 0) ? 2 : 33);
            chk("core_load_pulses", loads, (b == 0) ? 0 : 1);
            chk("core_step_cycles", steps, (b == 0) ? 0 : 32);
        end else if (flushAt >= 0) begin
            chk("stall_cycles_flush", stalls, flushAt);
        end
        $display("div a=%h b=%h signed=%0d stalls=%0d exp=%h%s", a, b, sgn, stalls, exp,
                 (flushAt >= 0) ? " flushed" : ((rstAt >= 0) ? " reset" : ""));
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        rst = 1'b0; flushE = 1'b0; div_validE = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chkResetState();
        chk("rst_stall", stall_divE, 1'b0);
        chk("rst_core_load", coreBus.core_load, 1'b0);
        chk("rst_core_step", coreBus.core_step, 1'b0);
        chk("rst_op_a", coreBus.core_op_a, 32'd0);
        chk("rst_op_b", coreBus.core_op_b, 32'd0);
        chk("rst_result", div_resultE, 64'd0);
        chk("rst_valid", div_result_validE, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; div_validE = 1'b0; signed_divE = 1'b0; flushE = 1'b0;
        srcaE = '0; srcbE = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkResetState();

        doDiv(32'd100, 32'd7, 1'b0, -1, -1);
        doDiv(-32'sd7, 32'd2, 1'b1, -1, -1);
        doDiv(32'd7, -32'sd2, 1'b1, -1, -1);
        doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1);
        doDiv(32'd5, 32'd0, 1'b0, -1, -1);

        // Flush at BUSY cnt=10: no strobe and the held result stays put.
        doDiv(32'd9, 32'd3, 1'b0, 11, -1);
        idle(2);
        chk("result_held_after_flush", div_resultE, lastRes);

        // Back-to-back divides.
        doDiv(32'd9, 32'd3, 1'b0, -1, -1);
        doDiv(32'd10, 32'd4, 1'b0, -1, -1);
        idle(3);
        chk("strobe_spacing", lastStrobe - prevStrobe, 34);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = -$urandom_range(1, 20);
                default: rb = ($urandom_range(0, 1) != 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            doDiv(ra, rb, 1'($urandom_range(0, 1)), -1, -1);
        end

        // Reset at BUSY cnt=5 returns everything to reset values.
        doDiv(32'd1234, 32'd11, 1'b1, -1, 6);
        idle(1);
        lastRes = '0;
        chkResetState();

        doDiv(32'd10, 32'd4, 1'b0, -1, -1);
        idle(4);
        chk("scoreboard_empty", sb.size(), 0);
        chk("strobe_count", strobes, expStrobes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
